rej_uniform_sampler: RTL and testbench
======================================

# rej_uniform_sampler

Rejection sampler that sits directly upstream of the matrix-A assembly in `sampleA`. It consumes the SHAKE128 squeeze stream for one (i,j) entry as 64-bit little-endian words. It slices that stream into 12-bit candidates and keeps those below q = 3329. It emits exactly 256 accepted coefficients, in order, to the polynomial buffer that forms `polymat_A_o`.

## Interface
- `Q`, 3329, modulus; candidates ≥ Q are rejected.
- `N`, 256, coefficients per polynomial.
- `W_IN`, 64, XOF word width (one Keccak lane).
- `CW`, 12, candidate/coefficient width.
- `clk_i`  input  1  single clock; all state updates on the rising edge.
- `rst_n_i`  input  1  synchronous active-low reset.
- `run_i`  input  1  one-cycle start pulse; sampled only in IDLE.
- `xof_data_i`  input  W_IN  squeeze word; bit 0 is the first stream bit.
- `xof_valid_i`  input  1  `xof_data_i` is valid.
- `xof_ready_o`  output  1  sampler accepts the word this cycle.
- `coef_o`  output  CW  accepted coefficient, in the range 0..Q-1.
- `coef_idx_o`  output  8  coefficient index, 0..N-1.
- `coef_valid_o`  output  1  `coef_o` and `coef_idx_o` are valid.
- `coef_ready_i`  input  1  downstream takes the coefficient.
- `busy_o`  output  1  high in RUN.
- `done_o`  output  1  one-cycle pulse after coefficient N-1 is handshaken.

## Operation
- **States:** IDLE, RUN, DONE.
  - IDLE → RUN on `run_i`.
  - RUN → DONE when the handshake of `coef_idx_o` = N-1 completes.
  - DONE → IDLE unconditionally after one cycle.
- **Bit buffer:** 76 bits wide, with a fill count `cnt` in the range 0..76.
  - `xof_ready_o` = (state == RUN) && (cnt ≤ 12). It is a registered-state decode and has no combinational path from `coef_ready_i`.
  - A word transfers when `xof_valid_i && xof_ready_o`. It is appended at bit position `cnt`, or at `cnt`-12 if an extraction happens in the same cycle.
- **Extraction:** occurs in RUN when `cnt ≥ 12` and the output slot is free (`!coef_valid_o || coef_ready_i`).
  - Take the low 12 bits as candidate `d`, shift the buffer right by 12, and set `cnt` -= 12.
  - This matches the Kyber Parse rule: for each 3-byte group, d1 = b0 | (b1 & 0xF) << 8 and d2 = b1 >> 4 | b2 << 4.
- **Accept/reject:**
  - If `d` < Q, load `d` into the output register, set `coef_valid_o`, and set `coef_idx_o` to the accept counter.
  - If `d` ≥ Q, discard it. The bits are consumed either way.
  - The accept counter increments on each output handshake.
- **Simultaneous push and extract:** `cnt`' = `cnt` + 64 - 12. This never exceeds 64, so the buffer cannot overflow.
- **Block boundary:** a 168-byte SHAKE128 block is exactly 112 candidates, so no bits straddle blocks. Block framing is the upstream block's job.
- **End of polynomial:** after index N-1, any leftover buffer bits are discarded. `cnt`, the accept counter and `coef_valid_o` are cleared on entry to DONE.
- **Ignored `run_i`:** a `run_i` pulse in RUN or DONE is ignored.
- **Reset:** reset takes priority in every state, including mid-polynomial. The next `run_i` starts a fresh polynomial from index 0.

## Timing
- **Reset values:** `xof_ready_o`=0, `coef_o`=0, `coef_idx_o`=0, `coef_valid_o`=0, `busy_o`=0, `done_o`=0, state=IDLE, `cnt`=0.
- **Start sequence:**
  - `run_i` in cycle t makes `busy_o` and `xof_ready_o` high in t+1.
  - A word accepted in t+1 enables the first extraction in t+2.
  - If that candidate is accepted, `coef_valid_o` rises in t+3.
- **Throughput:** at most one candidate per cycle; a 64-bit word is needed at most every 16/3 cycles on average.
- **Handshake rule:** while `coef_valid_o` is high and `coef_ready_i` is low, `coef_o` and `coef_idx_o` are held stable, and extraction stalls.
- **Upstream rule:** `xof_data_i` is captured only in the transfer cycle. The upstream block holds the word until ready.
- **Done timing:** `done_o` is high in the cycle after the last handshake (state DONE). `busy_o` is low in that same cycle.

## Structure
- **Shared package `sampler_pkg`:** holds Q, N, CW, W_IN, the `coef_t` (logic [11:0]) type and the state enum `rej_state_t`. `sampleA` and the NTT stages reuse Q, N and `coef_t`.
- **Sub-module `bit_unpacker`:** the 76-bit shift buffer and `cnt`, exposing push and pop-12 operations with the `cnt ≤ 12` and `cnt ≥ 12` flags.
- **Top level:** holds the FSM, the compare-with-Q logic, the output register and the accept counter.

## Test plan
- **Basic accept/reject:** run, then word 64'h0000_0000_00D0_0D01.
  - 0xD01 (3329) is rejected; 0xD00 (3328) is emitted as `coef_o`=3328, `coef_idx_o`=0.
  - The following zero chunks are emitted as 0 at indices 1, 2, …
- **Full polynomial:** 48 all-zero words produce 256 coefficients of value 0, indices 0..255, with `done_o` pulsing exactly once one cycle after the last handshake.
- **All-reject stream:** 20 words of 64'hFFFF_FFFF_FFFF_FFFF produce no `coef_valid_o`, and `xof_ready_o` keeps reasserting whenever `cnt` ≤ 12.
- **Backpressure:** hold `coef_ready_i` low for 10 cycles at index 5.
  - `coef_o` and `coef_idx_o` stay stable throughout; `xof_ready_o` drops once `cnt` > 12.
  - After release, the sequence continues at index 6 with no loss or duplication.
- **Kyber known answer:** rho = 256'h12345, (i,j)=(0,0) SHAKE128 stream from the golden model; all 256 coefficients match the reference model, in order.
- **Reset mid-operation:** assert `rst_n_i` low for 1 cycle at index 100.
  - All outputs return to their reset values the next cycle.
  - A new `run_i` restarts at index 0 and `done_o` appears only after index 255.

Source files
------------

// File: rtl/sampler_pkg.sv
// Shared constants and types for the Kyber matrix-A rejection sampler and its neighbours.
// Q, N and coef_t are also used by sampleA and the NTT stages.
package sampler_pkg;

  localparam int Q     = 3329;
  localparam int N     = 256;
  localparam int W_IN  = 64;
  localparam int CW    = 12;
  localparam int BUF_W = W_IN + CW;
  localparam int CNT_W = 7;

  typedef logic [CW-1:0] coef_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } rej_state_t;

endpackage

// File: rtl/bit_unpacker.sv
// 76-bit LSB-first shift buffer that accepts 64-bit pushes and yields 12-bit pops.
// A push that coincides with a pop lands just above the bits left after the pop.
module bit_unpacker
  import sampler_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            clr_i,
  input  logic            push_i,
  input  logic [W_IN-1:0] push_data_i,
  input  logic            pop_i,
  output logic [CW-1:0]   pop_data_o,
  output logic            can_push_o,
  output logic            can_pop_o
);

  logic [BUF_W-1:0] r_buf;
  logic [CNT_W-1:0] r_cnt;
  logic [BUF_W-1:0] w_base;
  logic [BUF_W-1:0] w_ext;
  logic [BUF_W-1:0] w_buf_nxt;
  logic [CNT_W-1:0] w_base_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  always_comb begin
    w_base     = r_buf;
    w_base_cnt = r_cnt;
    if (pop_i) begin
      w_base     = r_buf >> CW;
      w_base_cnt = r_cnt - CNT_W'(CW);
    end else begin
      w_base     = r_buf;
      w_base_cnt = r_cnt;
    end
    // bits above the fill count are always zero, so OR-ing the shifted word is enough
    w_ext = {{(BUF_W-W_IN){1'b0}}, push_data_i} << w_base_cnt;
    if (clr_i) begin
      w_buf_nxt = {BUF_W{1'b0}};
      w_cnt_nxt = {CNT_W{1'b0}};
    end else if (push_i) begin
      w_buf_nxt = w_base | w_ext;
      w_cnt_nxt = w_base_cnt + CNT_W'(W_IN);
    end else begin
      w_buf_nxt = w_base;
      w_cnt_nxt = w_base_cnt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_buf <= {BUF_W{1'b0}};
      r_cnt <= {CNT_W{1'b0}};
    end else begin
      r_buf <= w_buf_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

  assign pop_data_o = r_buf[CW-1:0];
  assign can_push_o = (r_cnt <= CNT_W'(CW));
  assign can_pop_o  = (r_cnt >= CNT_W'(CW));

endmodule

// File: rtl/rej_uniform_sampler.sv
// Kyber Parse rejection sampler: slices a SHAKE128 word stream into 12-bit candidates
// and emits the first 256 values below Q, in order, with a valid/ready handshake.
module rej_uniform_sampler
  import sampler_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            run_i,
  input  logic [W_IN-1:0] xof_data_i,
  input  logic            xof_valid_i,
  output logic            xof_ready_o,
  output logic [CW-1:0]   coef_o,
  output logic [7:0]      coef_idx_o,
  output logic            coef_valid_o,
  input  logic            coef_ready_i,
  output logic            busy_o,
  output logic            done_o
);

  rej_state_t r_state;
  rej_state_t w_state_nxt;
  coef_t      r_coef;
  logic [7:0] r_idx;
  logic [7:0] r_acc;
  logic       r_valid;

  coef_t      w_cand;
  logic       w_can_push;
  logic       w_can_pop;
  logic       w_push;
  logic       w_pop;
  logic       w_hs;
  logic       w_last_hs;
  logic       w_slot_free;
  logic       w_last_loaded;
  logic       w_accept;
  logic       w_in_run;

  assign w_in_run      = (r_state == ST_RUN);
  assign w_hs          = r_valid && coef_ready_i;
  assign w_last_loaded = r_valid && (r_idx == 8'(N - 1));
  assign w_last_hs     = w_in_run && w_hs && (r_idx == 8'(N - 1));
  assign w_slot_free   = !r_valid || coef_ready_i;
  // once coefficient N-1 sits in the output register nothing more is extracted
  assign w_pop         = w_in_run && w_can_pop && w_slot_free && !w_last_loaded;
  assign w_accept      = w_pop && (w_cand < coef_t'(Q));
  assign w_push        = xof_valid_i && xof_ready_o;

  bit_unpacker u_unpacker (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .clr_i       (w_last_hs),
    .push_i      (w_push),
    .push_data_i (xof_data_i),
    .pop_i       (w_pop),
    .pop_data_o  (w_cand),
    .can_push_o  (w_can_push),
    .can_pop_o   (w_can_pop)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (run_i) w_state_nxt = ST_RUN;
        else       w_state_nxt = ST_IDLE;
      end
      ST_RUN: begin
        if (w_last_hs) w_state_nxt = ST_DONE;
        else           w_state_nxt = ST_RUN;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // output slot and accept counter; a new load takes the index after any same-cycle handshake
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_coef  <= {CW{1'b0}};
      r_idx   <= 8'd0;
      r_acc   <= 8'd0;
      r_valid <= 1'b0;
    end else if (w_last_hs) begin
      r_coef  <= {CW{1'b0}};
      r_idx   <= 8'd0;
      r_acc   <= 8'd0;
      r_valid <= 1'b0;
    end else begin
      if (w_hs) begin
        r_acc <= r_acc + 8'd1;
      end else begin
        r_acc <= r_acc;
      end
      if (w_accept) begin
        r_coef  <= w_cand;
        r_idx   <= r_acc + {7'd0, w_hs};
        r_valid <= 1'b1;
      end else if (w_hs) begin
        r_valid <= 1'b0;
      end else begin
        r_valid <= r_valid;
      end
    end
  end

  assign xof_ready_o  = w_in_run && w_can_push;
  assign coef_o       = r_coef;
  assign coef_idx_o   = r_idx;
  assign coef_valid_o = r_valid;
  assign busy_o       = w_in_run;
  assign done_o       = (r_state == ST_DONE);

endmodule

// File: tb/tb_rej_uniform_sampler.sv
// Self-checking bench for rej_uniform_sampler: randomized word streams and ready patterns
// compared against a byte-level Kyber Parse reference model.
module tb_rej_uniform_sampler;

  logic        clk_i;
  logic        rst_n_i;
  logic        run_i;
  logic [63:0] xof_data_i;
  logic        xof_valid_i;
  logic        xof_ready_o;
  logic [11:0] coef_o;
  logic [7:0]  coef_idx_o;
  logic        coef_valid_o;
  logic        coef_ready_i;
  logic        busy_o;
  logic        done_o;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [63:0] words[$];
  int          exp_q[$];

  rej_uniform_sampler dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .run_i        (run_i),
    .xof_data_i   (xof_data_i),
    .xof_valid_i  (xof_valid_i),
    .xof_ready_o  (xof_ready_o),
    .coef_o       (coef_o),
    .coef_idx_o   (coef_idx_o),
    .coef_valid_o (coef_valid_o),
    .coef_ready_i (coef_ready_i),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input longint obs, input longint expv);
    n_checks++;
    if (obs == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
  endtask

  // Kyber Parse on the little-endian byte stream: two candidates per 3-byte group
  function automatic void build_expected();
    logic [7:0] bq[$];
    int d1;
    int d2;
    exp_q.delete();
    foreach (words[w])
      for (int k = 0; k < 8; k++) bq.push_back(words[w][8*k +: 8]);
    for (int g = 0; g + 2 < bq.size() && exp_q.size() < 256; g += 3) begin
      d1 = int'(bq[g]) + 256 * (int'(bq[g+1]) % 16);
      d2 = int'(bq[g+1]) / 16 + 16 * int'(bq[g+2]);
      if (d1 < 3329) exp_q.push_back(d1);
      if (d2 < 3329 && exp_q.size() < 256) exp_q.push_back(d2);
    end
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_xof_ready"},  xof_ready_o,  0);
    check_val({tag, "_coef"},       coef_o,       0);
    check_val({tag, "_coef_idx"},   coef_idx_o,   0);
    check_val({tag, "_coef_valid"}, coef_valid_o, 0);
    check_val({tag, "_busy"},       busy_o,       0);
    check_val({tag, "_done"},       done_o,       0);
  endtask

  task automatic fill_random(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back({$urandom(), $urandom()});
  endtask

  // mode 0: always ready, 1: random valid/ready gaps, 2: 10-cycle stall at index 5
  task automatic run_poly(input int mode, input int abort_at, input int first_exp);
    int  hs = 0;
    int  wp = 0;
    int  done_cnt = 0;
    int  last_hs_cyc = -10;
    int  stall = 0;
    int  post = 0;
    bit  xfer = 1'b0;
    bit  done_seen = 1'b0;
    bit  bp_used = 1'b0;
    bit  fin = 1'b0;
    logic [11:0] hold_coef;
    logic [7:0]  hold_idx;
    build_expected();
    xof_valid_i  = 1'b0;
    coef_ready_i = 1'b0;
    @(negedge clk_i);
    run_i = 1'b1;
    @(negedge clk_i);
    run_i = 1'b0;
    check_val("start_busy", busy_o, 1);
    check_val("start_xof_ready", xof_ready_o, 1);
    for (int cyc = 0; cyc < 6000 && !fin; cyc++) begin
      if (done_o) begin
        done_cnt++;
        done_seen = 1'b1;
        check_val("done_timing", cyc, last_hs_cyc + 1);
        check_val("done_busy_low", busy_o, 0);
        check_val("done_hs_total", hs, 256);
      end
      if (done_seen) begin
        post++;
        if (post > 4) fin = 1'b1;
      end
      if (abort_at >= 0 && hs == abort_at) begin
        rst_n_i      = 1'b0;
        xof_valid_i  = 1'b0;
        coef_ready_i = 1'b0;
        run_i        = 1'b0;
        @(negedge clk_i);
        rst_n_i = 1'b1;
        check_reset_outputs("midrst");
        return;
      end
      run_i = !done_seen && ($urandom_range(0, 15) == 0);
      if (!(xof_valid_i && !xfer)) begin
        xof_valid_i = (wp < words.size()) && (mode != 1 || $urandom_range(0, 3) != 0);
        if (wp < words.size()) xof_data_i = words[wp];
        else xof_data_i = 64'd0;
      end
      if (mode == 2 && !bp_used && coef_valid_o && coef_idx_o == 8'd5) begin
        stall     = 10;
        bp_used   = 1'b1;
        hold_coef = coef_o;
        hold_idx  = coef_idx_o;
      end
      if (stall > 0) begin
        coef_ready_i = 1'b0;
        check_val("bp_coef_stable", coef_o, hold_coef);
        check_val("bp_idx_stable", coef_idx_o, hold_idx);
        check_val("bp_valid_held", coef_valid_o, 1);
        if (stall == 1) check_val("bp_xof_ready_low", xof_ready_o, 0);
        stall--;
      end else if (mode == 1) begin
        coef_ready_i = ($urandom_range(0, 2) != 0);
      end else begin
        coef_ready_i = 1'b1;
      end
      xfer = xof_valid_i && xof_ready_o;
      if (xfer) wp++;
      if (coef_valid_o && coef_ready_i) begin
        if (hs < exp_q.size()) check_val("coef_value", coef_o, exp_q[hs]);
        else check_val("coef_count", hs, exp_q.size());
        check_val("coef_idx", coef_idx_o, hs);
        if (hs == 0 && first_exp >= 0) check_val("first_coef", coef_o, first_exp);
        hs++;
        last_hs_cyc = cyc;
      end
      @(negedge clk_i);
    end
    run_i        = 1'b0;
    xof_valid_i  = 1'b0;
    check_val("done_once", done_cnt, 1);
    check_val("hs_total", hs, 256);
    if (mode == 2) check_val("bp_reached", bp_used, 1);
  endtask

  task automatic run_reject();
    int wp = 0;
    int seen_valid = 0;
    xof_valid_i  = 1'b0;
    coef_ready_i = 1'b1;
    @(negedge clk_i);
    run_i = 1'b1;
    @(negedge clk_i);
    run_i = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (coef_valid_o) seen_valid++;
      xof_valid_i = (wp < 20);
      xof_data_i  = 64'hFFFF_FFFF_FFFF_FFFF;
      if (xof_valid_i && xof_ready_o) wp++;
      @(negedge clk_i);
    end
    xof_valid_i = 1'b0;
    check_val("reject_no_valid", seen_valid, 0);
    check_val("reject_words_taken", wp, 20);
    check_val("reject_ready_end", xof_ready_o, 1);
    check_val("reject_busy", busy_o, 1);
    rst_n_i = 1'b0;
    @(negedge clk_i);
    rst_n_i = 1'b1;
    check_reset_outputs("rejrst");
  endtask

  initial begin
    rst_n_i      = 1'b0;
    run_i        = 1'b0;
    xof_data_i   = 64'd0;
    xof_valid_i  = 1'b0;
    coef_ready_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check_reset_outputs("reset");
    rst_n_i = 1'b1;

    words.delete();
    words.push_back(64'h0000_0000_00D0_0D01);
    for (int i = 0; i < 48; i++) words.push_back(64'd0);
    run_poly(0, -1, 3328);

    words.delete();
    for (int i = 0; i < 48; i++) words.push_back(64'd0);
    run_poly(1, -1, 0);

    fill_random(80);
    run_poly(1, -1, -1);

    fill_random(80);
    run_poly(2, -1, -1);

    run_reject();

    fill_random(80);
    run_poly(1, 100, -1);
    fill_random(80);
    run_poly(0, -1, -1);

    repeat (3) @(negedge clk_i);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
